fetch_unit: RTL and testbench

- Instruction fetch stage; sits directly upstream of the byte-addressed, big-endian instruction memory.
- Owns the PC and drives 32-bit read requests to the memory.
- Captures returned words into a 2-entry instruction buffer and hands them to decode with a valid/ready handshake.
- Also handles control-flow redirects, enable/idle, and sticky fault reporting for misaligned or out-of-range PCs.

---
 rtl/fetch_unit.sv | 171 +++++++++++++++++
 tb/tb_fetch_unit.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues 32-bit reads to the instruction
// memory and queues returned words in a 2-entry buffer toward decode.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h8002_0000,
  parameter logic [31:0] MEM_BASE = 32'h8002_0000,
  parameter logic [31:0] MEM_SIZE = 32'h0010_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        fetch_enable,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] mem_address,
  output logic [1:0]  mem_access_size,
  output logic        mem_write,
  input  logic [31:0] mem_data,
  output logic        insn_valid,
  input  logic        insn_ready,
  output logic [31:0] insn,
  output logic [31:0] insn_pc,
  output logic        fault,
  output logic [31:0] fault_pc
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FAULT = 2'd2
  } state_t;

  // An address below MEM_BASE wraps to a huge offset and so fails the range test.
  function automatic logic pc_legal(input logic [31:0] pc);
    logic [31:0] off;
    off      = pc - MEM_BASE;
    pc_legal = (pc[1:0] == 2'b00) && (off <= (MEM_SIZE - 32'd4));
  endfunction

  state_t      state_r, state_s;
  logic [31:0] pc_r, pc_s;
  logic [1:0]  count_r, count_s;
  logic [31:0] hd_insn_r, hd_insn_s, hd_pc_r, hd_pc_s;
  logic [31:0] tl_insn_r, tl_insn_s, tl_pc_r, tl_pc_s;
  logic        fault_r, fault_s;
  logic [31:0] fault_pc_r, fault_pc_s;
  logic        pop_s, issue_s, pc_ok_s, redir_ok_s;

  // Next-state, buffer and PC update with redirect taking priority.
  always_comb begin
    state_s    = state_r;
    pc_s       = pc_r;
    count_s    = count_r;
    hd_insn_s  = hd_insn_r;
    hd_pc_s    = hd_pc_r;
    tl_insn_s  = tl_insn_r;
    tl_pc_s    = tl_pc_r;
    fault_s    = fault_r;
    fault_pc_s = fault_pc_r;
    pc_ok_s    = pc_legal(pc_r);
    redir_ok_s = pc_legal(redirect_pc);
    pop_s      = (count_r != 2'd0) && insn_ready;
    issue_s    = (state_r == ST_RUN) && pc_ok_s && !redirect &&
                 ((count_r != 2'd2) || pop_s);

    if (redirect) begin
      count_s = 2'd0;
      pc_s    = redirect_pc;
      if (redir_ok_s) begin
        fault_s = 1'b0;
      end else begin
        fault_s = fault_r;
      end
      case (state_r)
        ST_FAULT: begin
          if (redir_ok_s) begin
            state_s = fetch_enable ? ST_RUN : ST_IDLE;
          end else begin
            state_s = ST_FAULT;
          end
        end
        default: state_s = fetch_enable ? ST_RUN : ST_IDLE;
      endcase
    end else begin
      // Head always holds the oldest entry; tail is only used when two are held.
      case ({issue_s, pop_s})
        2'b01: begin
          hd_insn_s = tl_insn_r;
          hd_pc_s   = tl_pc_r;
          count_s   = count_r - 2'd1;
        end
        2'b10: begin
          if (count_r == 2'd0) begin
            hd_insn_s = mem_data;
            hd_pc_s   = pc_r;
          end else begin
            tl_insn_s = mem_data;
            tl_pc_s   = pc_r;
          end
          count_s = count_r + 2'd1;
        end
        2'b11: begin
          if (count_r == 2'd1) begin
            hd_insn_s = mem_data;
            hd_pc_s   = pc_r;
          end else begin
            hd_insn_s = tl_insn_r;
            hd_pc_s   = tl_pc_r;
            tl_insn_s = mem_data;
            tl_pc_s   = pc_r;
          end
        end
        default: count_s = count_r;
      endcase

      if (issue_s) begin
        pc_s = pc_r + 32'd4;
      end else begin
        pc_s = pc_r;
      end

      case (state_r)
        ST_IDLE: state_s = fetch_enable ? ST_RUN : ST_IDLE;
        ST_RUN: begin
          if (!pc_ok_s) begin
            state_s    = ST_FAULT;
            fault_s    = 1'b1;
            fault_pc_s = pc_r;
          end else begin
            state_s = fetch_enable ? ST_RUN : ST_IDLE;
          end
        end
        ST_FAULT: state_s = ST_FAULT;
        default:  state_s = ST_IDLE;
      endcase
    end
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= ST_IDLE;
      pc_r       <= RESET_PC;
      count_r    <= 2'd0;
      hd_insn_r  <= 32'd0;
      hd_pc_r    <= 32'd0;
      tl_insn_r  <= 32'd0;
      tl_pc_r    <= 32'd0;
      fault_r    <= 1'b0;
      fault_pc_r <= 32'd0;
    end else begin
      state_r    <= state_s;
      pc_r       <= pc_s;
      count_r    <= count_s;
      hd_insn_r  <= hd_insn_s;
      hd_pc_r    <= hd_pc_s;
      tl_insn_r  <= tl_insn_s;
      tl_pc_r    <= tl_pc_s;
      fault_r    <= fault_s;
      fault_pc_r <= fault_pc_s;
    end
  end

  assign mem_address     = pc_r;
  assign mem_access_size = 2'b10;
  assign mem_write       = 1'b0;
  assign insn_valid      = (count_r != 2'd0);
  assign insn            = hd_insn_r;
  assign insn_pc         = hd_pc_r;
  assign fault           = fault_r;
  assign fault_pc        = fault_pc_r;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a queue-based behavioural model checked every
// cycle, plus hand-computed expectations along the directed scenario.
module tb_fetch_unit;

  localparam logic [31:0] BASE = 32'h8002_0000;
  localparam logic [31:0] SIZE = 32'h0010_0000;
  localparam int M_IDLE = 0, M_RUN = 1, M_FAULT = 2;

  logic        clk, reset, fetch_enable, redirect, insn_ready;
  logic [31:0] redirect_pc, mem_address, mem_data, insn, insn_pc, fault_pc;
  logic [1:0]  mem_access_size;
  logic        mem_write, insn_valid, fault;

  int n_cmp = 0;
  int n_bad = 0;

  fetch_unit dut (
    .clk(clk), .reset(reset), .fetch_enable(fetch_enable),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .mem_address(mem_address), .mem_access_size(mem_access_size),
    .mem_write(mem_write), .mem_data(mem_data),
    .insn_valid(insn_valid), .insn_ready(insn_ready),
    .insn(insn), .insn_pc(insn_pc), .fault(fault), .fault_pc(fault_pc)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a >= BASE && a <= BASE + 32'd12) mem_word = ((a - BASE) >> 2) + 32'd1;
    else mem_word = a ^ 32'hC0DE_0000;
  endfunction

  function automatic bit legal(input logic [31:0] pc);
    legal = (pc[1:0] == 2'b00) && ((pc - BASE) <= (SIZE - 32'd4));
  endfunction

  assign mem_data = mem_word(mem_address);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: program-order queue of {word, pc}
  logic [63:0] mq[$];
  logic [31:0] m_pc = BASE, m_fpc = 32'd0;
  bit          m_fault = 1'b0, m_live = 1'b0;
  int          m_mode = M_IDLE;

  initial begin
    forever begin
      @(posedge clk);
      if (reset) begin
        mq.delete(); m_pc = BASE; m_fault = 0; m_fpc = 0; m_mode = M_IDLE; m_live = 1;
      end else if (redirect) begin
        mq.delete();
        m_pc = redirect_pc;
        if (legal(redirect_pc)) begin
          m_fault = 0;
          m_mode = fetch_enable ? M_RUN : M_IDLE;
        end else if (m_mode != M_FAULT) begin
          m_mode = fetch_enable ? M_RUN : M_IDLE;
        end
      end else begin
        bit pop, iss;
        pop = (mq.size() > 0) && insn_ready;
        iss = (m_mode == M_RUN) && legal(m_pc) && (mq.size() < 2 || pop);
        if (pop) void'(mq.pop_front());
        if (m_mode == M_RUN && !legal(m_pc)) begin
          m_fault = 1; m_fpc = m_pc; m_mode = M_FAULT;
        end else if (m_mode == M_RUN) begin
          m_mode = fetch_enable ? M_RUN : M_IDLE;
        end else if (m_mode == M_IDLE && fetch_enable) begin
          m_mode = M_RUN;
        end
        if (iss) begin
          mq.push_back({mem_word(m_pc), m_pc});
          m_pc = m_pc + 32'd4;
        end
      end
    end
  end

  // Per-cycle comparison against the model
  initial begin
    forever begin
      @(negedge clk);
      if (m_live) begin
        check("mem_address", mem_address, m_pc);
        check("mem_access_size", {30'd0, mem_access_size}, 32'd2);
        check("mem_write", {31'd0, mem_write}, 32'd0);
        check("insn_valid", {31'd0, insn_valid}, {31'd0, mq.size() != 0});
        if (mq.size() != 0) begin
          check("insn", insn, mq[0][63:32]);
          check("insn_pc", insn_pc, mq[0][31:0]);
        end
        check("fault", {31'd0, fault}, {31'd0, m_fault});
        check("fault_pc", fault_pc, m_fpc);
      end
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; fetch_enable = 1'b0; redirect = 1'b0;
    redirect_pc = 32'd0; insn_ready = 1'b1;
    repeat (2) step();
    check("rst_mem_address", mem_address, 32'h8002_0000);
    check("rst_valid", {31'd0, insn_valid}, 32'd0);
    check("rst_insn", insn, 32'd0);
    check("rst_insn_pc", insn_pc, 32'd0);
    check("rst_fault", {31'd0, fault}, 32'd0);
    check("rst_fault_pc", fault_pc, 32'd0);
    check("rst_size", {30'd0, mem_access_size}, 32'd2);

    // Sequential fetch: first word two cycles after enable, then one per cycle
    reset = 1'b0; fetch_enable = 1'b1;
    step(); step();
    check("seq_valid", {31'd0, insn_valid}, 32'd1);
    check("seq_insn0", insn, 32'd1);
    check("seq_pc0", insn_pc, 32'h8002_0000);
    for (int k = 1; k < 4; k++) begin
      step();
      check("seq_insn", insn, k + 1);
      check("seq_pc", insn_pc, 32'h8002_0000 + 4 * k);
    end

    // Backpressure: head frozen at word 4, one more word queued, PC stalls
    insn_ready = 1'b0;
    repeat (5) step();
    check("bp_insn", insn, 32'd4);
    check("bp_pc", insn_pc, 32'h8002_000C);
    check("bp_mem_address", mem_address, 32'h8002_0014);
    insn_ready = 1'b1;
    step();
    check("bp_resume_insn", insn, 32'h40DC_0010);
    check("bp_resume_pc", insn_pc, 32'h8002_0010);

    // Redirect while two entries are held and decode is popping
    redirect = 1'b1; redirect_pc = 32'h8002_0100;
    step();
    redirect = 1'b0;
    check("rd_valid0", {31'd0, insn_valid}, 32'd0);
    check("rd_mem_address", mem_address, 32'h8002_0100);
    step();
    check("rd_valid1", {31'd0, insn_valid}, 32'd1);
    check("rd_pc", insn_pc, 32'h8002_0100);
    check("rd_insn", insn, 32'h40DC_0100);

    // Last legal word is delivered, the following PC faults
    redirect = 1'b1; redirect_pc = 32'h8011_FFFC;
    step();
    redirect = 1'b0;
    step();
    check("eow_pc", insn_pc, 32'h8011_FFFC);
    check("eow_valid", {31'd0, insn_valid}, 32'd1);
    step();
    check("eow_fault", {31'd0, fault}, 32'd1);
    check("eow_fault_pc", fault_pc, 32'h8012_0000);
    step();
    check("eow_no_issue", {31'd0, insn_valid}, 32'd0);
    check("eow_pc_hold", mem_address, 32'h8012_0000);

    // Legal redirect clears the fault
    redirect = 1'b1; redirect_pc = 32'h8002_0000;
    step();
    redirect = 1'b0;
    check("clr_fault", {31'd0, fault}, 32'd0);
    step();
    check("clr_pc", insn_pc, 32'h8002_0000);

    // Misaligned redirect faults in the following cycle
    redirect = 1'b1; redirect_pc = 32'h8002_0002;
    step();
    redirect = 1'b0;
    check("mis_fault0", {31'd0, fault}, 32'd0);
    step();
    check("mis_fault1", {31'd0, fault}, 32'd1);
    check("mis_fault_pc", fault_pc, 32'h8002_0002);
    redirect = 1'b1; redirect_pc = 32'h8002_0000;
    step();
    redirect = 1'b0;
    check("mis_clr", {31'd0, fault}, 32'd0);
    step();
    check("mis_resume_pc", insn_pc, 32'h8002_0000);
    check("mis_resume_insn", insn, 32'd1);

    // Reset with a full buffer
    insn_ready = 1'b0;
    step();
    reset = 1'b1;
    step();
    check("mrst_valid", {31'd0, insn_valid}, 32'd0);
    check("mrst_mem_address", mem_address, 32'h8002_0000);
    check("mrst_fault", {31'd0, fault}, 32'd0);
    check("mrst_insn", insn, 32'd0);
    reset = 1'b0; insn_ready = 1'b1;
    step();
    check("mrst_idle", {31'd0, insn_valid}, 32'd0);
    step();
    check("mrst_restart", insn, 32'd1);
    repeat (2) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
